local_ni: RTL

- Local network interface attached to the router's local port, on the same clk as the router.
- Inject path: takes host requests, builds 40-bit packets, and writes them into the router's local input FIFO (wdata_local/wr_en_local, throttled by full_local).
- Eject path: consumes the router's local output (data_to_local/wr_next_local_en) into a small buffer, drives back-pressure on next_full_local, and presents packets to the host with a valid/ready handshake.

---
 rtl/local_ni_pkg.sv | 46 ++++
 rtl/local_ni_if.sv | 38 +++
 rtl/local_ni_fifo.sv | 56 +++++
 rtl/local_ni.sv | 136 +++++++++++++
 4 files changed

// File: rtl/local_ni_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | local_ni_pkg                                                     |
// | Packet field layout, sequence limits and node addresses shared   |
// | by the network interface and the router routing stage.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package local_ni_pkg;

  localparam int WD     = 40;
  localparam int DST_HI = 39;
  localparam int DST_LO = 38;
  localparam int SRC_HI = 37;
  localparam int SRC_LO = 36;
  localparam int SEQ_HI = 35;
  localparam int SEQ_LO = 32;
  localparam int PAY_HI = 31;
  localparam int PAY_LO = 0;

  localparam logic [3:0] SEQ_FIRST = 4'd1;
  localparam logic [3:0] SEQ_LAST  = 4'd15;

  localparam logic [1:0] NODE_00 = 2'b00;
  localparam logic [1:0] NODE_01 = 2'b01;
  localparam logic [1:0] NODE_10 = 2'b10;
  localparam logic [1:0] NODE_11 = 2'b11;

  typedef enum logic [0:0] {
    INJ_IDLE = 1'b0,
    INJ_HOLD = 1'b1
  } inj_state_t;

  function automatic logic [WD-1:0] build_pkt(input logic [1:0]  dst,
                                              input logic [1:0]  src,
                                              input logic [3:0]  seq,
                                              input logic [31:0] pay);
    return {dst, src, seq, pay};
  endfunction

  // Sequence skips 0 so that an injected word can never be all-zero.
  function automatic logic [3:0] next_seq(input logic [3:0] seq);
    return (seq == SEQ_LAST) ? SEQ_FIRST : seq + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/local_ni_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | local_ni_if                                                      |
// | Host inject/eject handshakes and router local-port link.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface local_ni_if #(
  parameter int WD = local_ni_pkg::WD
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_dst;
  logic [31:0]   req_payload;
  logic [WD-1:0] wdata_local;
  logic          wr_en_local;
  logic          full_local;
  logic [WD-1:0] data_to_local;
  logic          wr_next_local_en;
  logic          next_full_local;
  logic          rx_valid;
  logic          rx_ready;
  logic [WD-1:0] rx_data;

  modport slave (
    input  req_valid, req_dst, req_payload, full_local,
           data_to_local, wr_next_local_en, rx_ready,
    output req_ready, wdata_local, wr_en_local, next_full_local,
           rx_valid, rx_data
  );

  modport master (
    output req_valid, req_dst, req_payload, full_local,
           data_to_local, wr_next_local_en, rx_ready,
    input  req_ready, wdata_local, wr_en_local, next_full_local,
           rx_valid, rx_data
  );
endinterface
`default_nettype wire

// File: rtl/local_ni_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ni_sync_fifo                                                     |
// | First-word fall-through eject buffer; head reads 0 when empty.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module ni_sync_fifo #(
  parameter int WD    = 40,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          push,
  input  wire logic          pop,
  input  wire logic [WD-1:0] din,
  output logic      [WD-1:0] head,
  output logic      [AW:0]   count,
  output logic               full,
  output logic               empty
);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WD-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == C_DEPTH);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/local_ni.sv
`default_nettype none
// +------------------------------------------------------------------+
// | local_ni                                                         |
// | Router local-port network interface: packet injector + eject buf.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module local_ni #(
  parameter int         WD      = local_ni_pkg::WD,
  parameter logic [1:0] MY_ADDR = 2'b11,
  parameter int         DEPTH   = 8,
  parameter int         AW      = 3,
  parameter int         SLACK   = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  local_ni_if.slave   bus,
  output logic [15:0] tx_cnt,
  output logic [15:0] rx_cnt,
  output logic        err_misroute,
  output logic        err_overflow
);
  import local_ni_pkg::*;

  localparam logic [AW:0] C_HWM = (AW+1)'(DEPTH - SLACK);

  inj_state_t    r_state;
  logic [WD-1:0] r_tx;
  logic [3:0]    r_seq;
  logic [15:0]   r_tx_cnt;
  logic [15:0]   r_rx_cnt;
  logic          r_full_d1;
  logic          r_full_d2;
  logic          r_err_mis;
  logic          r_err_ovf;

  logic          w_hold;
  logic          w_ready;
  logic          w_wr;
  logic          w_new;
  logic          w_mine;
  logic          w_push;
  logic          w_pop;
  logic [WD-1:0] w_head;
  logic [AW:0]   w_count;
  logic          w_ff_full;
  logic          w_ff_empty;

  // State is reset asynchronously, so wr_en_local drops the moment rst_n rises.
  assign w_hold  = (r_state == INJ_HOLD);
  assign w_ready = w_hold ? !bus.full_local : 1'b1;
  assign w_wr    = w_hold && !bus.full_local;

  assign bus.req_ready   = w_ready;
  assign bus.wr_en_local = w_wr;
  assign bus.wdata_local = w_hold ? r_tx : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= INJ_IDLE;
      r_tx     <= '0;
      r_seq    <= SEQ_FIRST;
      r_tx_cnt <= '0;
    end else begin
      case (r_state)
        INJ_IDLE: begin
          if (bus.req_valid) begin
            r_tx    <= build_pkt(bus.req_dst, MY_ADDR, r_seq, bus.req_payload);
            r_seq   <= next_seq(r_seq);
            r_state <= INJ_HOLD;
          end
        end
        INJ_HOLD: begin
          if (!bus.full_local) begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
            if (bus.req_valid) begin
              r_tx  <= build_pkt(bus.req_dst, MY_ADDR, r_seq, bus.req_payload);
              r_seq <= next_seq(r_seq);
            end else begin
              r_state <= INJ_IDLE;
            end
          end
        end
        default: r_state <= INJ_IDLE;
      endcase
    end
  end

  // The router reacts to next_full two edges late; samples held during that
  // stall are repeats of an already-accepted word.
  assign w_new  = bus.wr_next_local_en && !r_full_d2;
  assign w_mine = (bus.data_to_local[DST_HI:DST_LO] == MY_ADDR);
  assign w_push = w_new && w_mine && !w_ff_full;
  assign w_pop  = !w_ff_empty && bus.rx_ready;

  ni_sync_fifo #(
    .WD    (WD),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_eject_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.data_to_local),
    .head  (w_head),
    .count (w_count),
    .full  (w_ff_full),
    .empty (w_ff_empty)
  );

  assign bus.next_full_local = (w_count >= C_HWM);
  assign bus.rx_valid        = !w_ff_empty;
  assign bus.rx_data         = w_head;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_full_d1 <= 1'b0;
      r_full_d2 <= 1'b0;
      r_err_mis <= 1'b0;
      r_err_ovf <= 1'b0;
      r_rx_cnt  <= '0;
    end else begin
      r_full_d1 <= bus.next_full_local;
      r_full_d2 <= r_full_d1;
      if (w_new && !w_mine)             r_err_mis <= 1'b1;
      if (w_new && w_mine && w_ff_full) r_err_ovf <= 1'b1;
      if (w_pop)                        r_rx_cnt  <= r_rx_cnt + 16'd1;
    end
  end

  assign tx_cnt       = r_tx_cnt;
  assign rx_cnt       = r_rx_cnt;
  assign err_misroute = r_err_mis;
  assign err_overflow = r_err_ovf;
endmodule
`default_nettype wire
